// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and the hazard controller state type.
// Used by both the main control decoder and hazard_ctrl.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BGEZ  = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BGT   = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_FLUSH = 6'd32;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hazState_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection between the load in ID/EX and the
// instruction waiting in IF/ID.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [5:0] ifidOp,
    input  logic [4:0] ifidRs,
    input  logic [4:0] ifidRt,
    input  logic       idexMemRead,
    input  logic [4:0] idexRt,
    output logic       loadUse
);

    logic rtIsSrc;

    // Only these opcodes read rt as a source; for I-type ALU ops and loads rt is a destination.
    always_comb begin
        case (ifidOp)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_BGT, OP_SW: rtIsSrc = 1'b1;
            default:                                  rtIsSrc = 1'b0;
        endcase
    end

    assign loadUse = idexMemRead && (idexRt != 5'd0) &&
                     ((idexRt == ifidRs) || (rtIsSrc && (idexRt == ifidRt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch and jump flushes,
// and selection of the opcode seen by the control decoder.
// Optional performance counters are enabled with `define HAZARD_CTRL_PERF_EN.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter logic [5:0]  BUBBLE_OP         = OP_FLUSH
`ifdef HAZARD_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W             = 32
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] ifid_op_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_i,
    input  logic       branch_taken_i,
    input  logic       jump_i,
    output logic [5:0] op_o,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_flush_o,
    output logic       exmem_flush_o,
    output logic       stalling_o
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam int CNT_BITS = 2;

    hazState_t           stateReg, stateNext;
    logic [CNT_BITS-1:0] cntReg, cntNext;
    logic                loadUse;

    hazard_detect uDetect (
        .ifidOp      (ifid_op_i),
        .ifidRs      (ifid_rs_i),
        .ifidRt      (ifid_rt_i),
        .idexMemRead (idex_memread_i),
        .idexRt      (idex_rt_i),
        .loadUse     (loadUse)
    );

    always_comb begin
        op_o          = ifid_op_i;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        stalling_o    = 1'b0;
        stateNext     = stateReg;
        cntNext       = cntReg;

        if (branch_taken_i) begin
            // A resolved branch squashes everything younger, including a stall in progress.
            op_o          = BUBBLE_OP;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            stateNext     = RUN;
            cntNext       = '0;
        end else if (stateReg == STALL) begin
            op_o         = BUBBLE_OP;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            stalling_o   = 1'b1;
            cntNext      = cntReg - 1'b1;
            stateNext    = (cntReg == 2'd1) ? RUN : STALL;
        end else if (loadUse) begin
            op_o         = BUBBLE_OP;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                stateNext = STALL;
                cntNext   = CNT_BITS'(LOAD_STALL_CYCLES - 1);
            end
        end else if (jump_i) begin
            // The jump itself still decodes; only the wrongly fetched successor is dropped.
            ifid_flush_o = 1'b1;
        end

        if (rst_i) begin
            op_o          = BUBBLE_OP;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            stalling_o    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stateReg <= RUN;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stallCntReg, flushCntReg;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCntReg <= '0;
            flushCntReg <= '0;
        end else begin
            if (!pc_write_o && (stallCntReg != '1))
                stallCntReg <= stallCntReg + 1'b1;
            if (branch_taken_i && (flushCntReg != '1))
                flushCntReg <= flushCntReg + 1'b1;
        end
    end

    assign stall_cnt_o = stallCntReg;
    assign flush_cnt_o = flushCntReg;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with single-cycle load stalls and
// one with three-cycle stalls, both driven by the same stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] ifidOp;
    logic [4:0] ifidRs, ifidRt, idexRt;
    logic       idexMemRead, branchTaken, jump;

    logic [5:0] op1, op3;
    logic       pcw1, ifw1, iff1, idf1, exf1, stl1;
    logic       pcw3, ifw3, iff3, idf3, exf3, stl3;
    logic [11:0] obs1, obs3;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stallCnt1, flushCnt1, stallCnt3, flushCnt3;
`endif

    int nTests = 0;
    int nFail  = 0;

    // Observation vector: {op, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, stalling}
    assign obs1 = {op1, pcw1, ifw1, iff1, idf1, exf1, stl1};
    assign obs3 = {op3, pcw3, ifw3, iff3, idf3, exf3, stl3};

    localparam logic [11:0] RESET_V  = {6'd32, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [11:0] STALL_V  = {6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [11:0] STALLS_V = {6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [11:0] BRANCH_V = {6'd32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [11:0] JUMP_V   = {6'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [11:0] NO_STL   = 12'hFFE;
    localparam logic [11:0] NO_IFW   = 12'hFEF;

    function automatic logic [11:0] normalV(input logic [5:0] op);
        return {op, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .ifid_op_i(ifidOp), .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt),
        .idex_memread_i(idexMemRead), .idex_rt_i(idexRt), .branch_taken_i(branchTaken), .jump_i(jump),
        .op_o(op1), .pc_write_o(pcw1), .ifid_write_o(ifw1), .ifid_flush_o(iff1),
        .idex_flush_o(idf1), .exmem_flush_o(exf1), .stalling_o(stl1)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt_o(stallCnt1), .flush_cnt_o(flushCnt1)
`endif
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .ifid_op_i(ifidOp), .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt),
        .idex_memread_i(idexMemRead), .idex_rt_i(idexRt), .branch_taken_i(branchTaken), .jump_i(jump),
        .op_o(op3), .pc_write_o(pcw3), .ifid_write_o(ifw3), .ifid_flush_o(iff3),
        .idex_flush_o(idf3), .exmem_flush_o(exf3), .stalling_o(stl3)
`ifdef HAZARD_CTRL_PERF_EN
        , .stall_cnt_o(stallCnt3), .flush_cnt_o(flushCnt3)
`endif
    );

    // Waits for the falling edge, applies one cycle of inputs and lets them settle.
    task automatic drive(input logic r, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] xrt, input logic br, input logic j);
        @(negedge clk);
        rst = r; ifidOp = op; ifidRs = rs; ifidRt = rt;
        idexMemRead = mr; idexRt = xrt; branchTaken = br; jump = j;
        #1;
    endtask

    task automatic doReset();
        drive(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 6'd35, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1);
        nTests++;
        if (obs1 !== RESET_V) begin
            nFail++; $display("FAIL reset_n1: got %h expected %h", obs1, RESET_V);
        end
        nTests++;
        if (obs3 !== RESET_V) begin
            nFail++; $display("FAIL reset_n3: got %h expected %h", obs3, RESET_V);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_load_use_rs();
        doReset();
        drive(1'b0, 6'd0, 5'd5, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0);
        nTests++;
        if (obs1 !== STALL_V) begin
            nFail++; $display("FAIL lu_rs_stall: got %h expected %h", obs1, STALL_V);
        end
        drive(1'b0, 6'd0, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
        nTests++;
        if (obs1 !== normalV(6'd0)) begin
            nFail++; $display("FAIL lu_rs_resume: got %h expected %h", obs1, normalV(6'd0));
        end
        $display("[TB] test_load_use_rs done");
    endtask

    task automatic test_false_hazard();
        doReset();
        // addi writes rt, so matching rt is not a hazard
        drive(1'b0, 6'd8, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        nTests++;
        if (obs1 !== normalV(6'd8)) begin
            nFail++; $display("FAIL false_addi_n1: got %h expected %h", obs1, normalV(6'd8));
        end
        nTests++;
        if (obs3 !== normalV(6'd8)) begin
            nFail++; $display("FAIL false_addi_n3: got %h expected %h", obs3, normalV(6'd8));
        end
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        nTests++;
        if (obs1 !== normalV(6'd0)) begin
            nFail++; $display("FAIL false_r0_n1: got %h expected %h", obs1, normalV(6'd0));
        end
        nTests++;
        if (obs3 !== normalV(6'd0)) begin
            nFail++; $display("FAIL false_r0_n3: got %h expected %h", obs3, normalV(6'd0));
        end
        // beq reads rt, so matching rt is a hazard
        drive(1'b0, 6'd4, 5'd9, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        nTests++;
        if (obs1 !== STALL_V) begin
            nFail++; $display("FAIL beq_rt_stall: got %h expected %h", obs1, STALL_V);
        end
        $display("[TB] test_false_hazard done");
    endtask

    task automatic test_long_stall();
        doReset();
        drive(1'b0, 6'd43, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== STALL_V) begin
            nFail++; $display("FAIL long_c1: got %h expected %h", obs3, STALL_V);
        end
        // hazard inputs held: must be ignored while the stall runs down
        drive(1'b0, 6'd43, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== STALLS_V) begin
            nFail++; $display("FAIL long_c2: got %h expected %h", obs3, STALLS_V);
        end
        drive(1'b0, 6'd43, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== STALLS_V) begin
            nFail++; $display("FAIL long_c3: got %h expected %h", obs3, STALLS_V);
        end
        drive(1'b0, 6'd43, 5'd1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== normalV(6'd43)) begin
            nFail++; $display("FAIL long_c4: got %h expected %h", obs3, normalV(6'd43));
        end
`ifdef HAZARD_CTRL_PERF_EN
        nTests++;
        if (stallCnt3 !== 32'd3) begin
            nFail++; $display("FAIL perf_stall3: got %0d expected 3", stallCnt3);
        end
`endif
        $display("[TB] test_long_stall done");
    endtask

    task automatic test_branch_mid_stall();
        doReset();
        drive(1'b0, 6'd0, 5'd4, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== STALL_V) begin
            nFail++; $display("FAIL br_c1: got %h expected %h", obs3, STALL_V);
        end
        drive(1'b0, 6'd0, 5'd4, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        nTests++;
        if ((obs3 & NO_STL) !== (BRANCH_V & NO_STL)) begin
            nFail++; $display("FAIL br_mid_n3: got %h expected %h", obs3 & NO_STL, BRANCH_V & NO_STL);
        end
        nTests++;
        if (obs1 !== BRANCH_V) begin
            nFail++; $display("FAIL br_n1: got %h expected %h", obs1, BRANCH_V);
        end
        drive(1'b0, 6'd0, 5'd4, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== normalV(6'd0)) begin
            nFail++; $display("FAIL br_after: got %h expected %h", obs3, normalV(6'd0));
        end
`ifdef HAZARD_CTRL_PERF_EN
        nTests++;
        if (flushCnt1 !== 32'd1) begin
            nFail++; $display("FAIL perf_flush1: got %0d expected 1", flushCnt1);
        end
`endif
        $display("[TB] test_branch_mid_stall done");
    endtask

    task automatic test_jump();
        doReset();
        drive(1'b0, 6'd2, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        nTests++;
        if ((obs1 & NO_IFW) !== (JUMP_V & NO_IFW)) begin
            nFail++; $display("FAIL jump: got %h expected %h", obs1 & NO_IFW, JUMP_V & NO_IFW);
        end
        drive(1'b0, 6'd0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        nTests++;
        if (obs1 !== normalV(6'd0)) begin
            nFail++; $display("FAIL jump_after: got %h expected %h", obs1, normalV(6'd0));
        end
        drive(1'b0, 6'd2, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        nTests++;
        if (obs1 !== BRANCH_V) begin
            nFail++; $display("FAIL jump_vs_branch: got %h expected %h", obs1, BRANCH_V);
        end
        $display("[TB] test_jump done");
    endtask

    task automatic test_reset_in_stall();
        doReset();
        drive(1'b0, 6'd0, 5'd8, 5'd1, 1'b1, 5'd8, 1'b0, 1'b0);
        drive(1'b0, 6'd0, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== STALLS_V) begin
            nFail++; $display("FAIL rs_in_stall: got %h expected %h", obs3, STALLS_V);
        end
        drive(1'b1, 6'd0, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== RESET_V) begin
            nFail++; $display("FAIL rs_during: got %h expected %h", obs3, RESET_V);
        end
        drive(1'b0, 6'd13, 5'd8, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        nTests++;
        if (obs3 !== normalV(6'd13)) begin
            nFail++; $display("FAIL rs_after: got %h expected %h", obs3, normalV(6'd13));
        end
`ifdef HAZARD_CTRL_PERF_EN
        nTests++;
        if (stallCnt3 !== 32'd0 || flushCnt3 !== 32'd0) begin
            nFail++; $display("FAIL perf_clear: got %0d/%0d expected 0/0", stallCnt3, flushCnt3);
        end
`endif
        $display("[TB] test_reset_in_stall done");
    endtask

    initial begin
        rst = 1'b1; ifidOp = '0; ifidRs = '0; ifidRt = '0;
        idexMemRead = 1'b0; idexRt = '0; branchTaken = 1'b0; jump = 1'b0;
        test_reset();
        test_load_use_rs();
        test_false_hazard();
        test_long_stall();
        test_branch_mid_stall();
        test_jump();
        test_reset_in_stall();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
